// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped L1 cache.
// Derived widths follow from the line and capacity sizes.
package cache_pkg;

    localparam int SIZE           = 32768;
    localparam int LINE_SIZE      = 256;
    localparam int WORD_SIZE      = 32;
    localparam int ADDR_SIZE      = 32;
    localparam int NUM_LINES      = SIZE / LINE_SIZE;
    localparam int OFFSET_W       = $clog2(LINE_SIZE / 8);
    localparam int INDEX_W        = $clog2(NUM_LINES);
    localparam int TAG_W          = ADDR_SIZE - INDEX_W - OFFSET_W;
    localparam int WORD_SEL_W     = OFFSET_W - 2;
    localparam int WORD_SHIFT     = $clog2(WORD_SIZE);

    typedef enum logic [1:0] {
        READY = 2'd0,
        EVICT = 2'd1,
        FILL  = 2'd2
    } cache_state_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } access_size_t;

    // Store data is right-aligned; misaligned low address bits are simply truncated.
    function automatic logic [WORD_SIZE-1:0] merge_store(
        input logic [WORD_SIZE-1:0] old_word,
        input logic [WORD_SIZE-1:0] wdata,
        input access_size_t         size,
        input logic [1:0]           byte_sel
    );
        logic [WORD_SIZE-1:0] res;
        res = old_word;
        case (size)
            BYTE:    res[{byte_sel, 3'b000} +: 8]     = wdata[7:0];
            HALF:    res[{byte_sel[1], 4'b0000} +: 16] = wdata[15:0];
            default: res = wdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cache_interface.sv
// Datapath-side request bus: the datapath is master, the cache is slave.
interface cache_interface;
    import cache_pkg::*;

    logic [ADDR_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] data_wr;
    access_size_t         wr_size;
    logic                 valid;
    logic                 write;
    logic [WORD_SIZE-1:0] data_rd;
    logic                 hit;

    modport master (output addr, data_wr, wr_size, valid, write, input data_rd, hit);
    modport slave  (input addr, data_wr, wr_size, valid, write, output data_rd, hit);
endinterface

// File: rtl/memory_interface.sv
// Line-transfer bus from the cache (master) toward the memory arbiter (slave).
interface memory_interface;
    import cache_pkg::*;

    logic [ADDR_SIZE-1:0] addr;
    logic [LINE_SIZE-1:0] data_wr;
    logic                 valid;
    logic                 write;
    logic [LINE_SIZE-1:0] data_rd;
    logic                 ready;

    modport master (output addr, data_wr, valid, write, input data_rd, ready);
    modport slave  (input addr, data_wr, valid, write, output data_rd, ready);
endinterface

// File: rtl/cache.sv
// Direct-mapped, write-back, write-allocate L1 cache with zero-cycle hits.
// Misses run EVICT (dirty victim only) then FILL over the memory bus.
//
// state | meaning
// READY | serving hits; a miss selects EVICT or FILL
// EVICT | writing the dirty victim line back to memory
// FILL  | fetching the requested line from memory
module cache
    import cache_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    cache_interface.slave   cache_bus,
    memory_interface.master memory_bus
);

    cache_state_t          state_q, state_d;
    logic [NUM_LINES-1:0]  valid_q, valid_d;
    logic [NUM_LINES-1:0]  dirty_q, dirty_d;
    logic [TAG_W-1:0]      tag_q  [NUM_LINES];
    logic [LINE_SIZE-1:0]  data_q [NUM_LINES];

    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_W-1:0]    req_idx;
    logic [WORD_SEL_W-1:0] req_word;
    logic [LINE_SIZE-1:0]  cur_line;
    logic [WORD_SIZE-1:0]  cur_word;
    logic                  lookup_hit;

    logic                  line_we;
    logic [LINE_SIZE-1:0]  line_wdata;
    logic                  tag_we;

    assign req_tag  = cache_bus.addr[ADDR_SIZE-1 -: TAG_W];
    assign req_idx  = cache_bus.addr[OFFSET_W +: INDEX_W];
    assign req_word = cache_bus.addr[2 +: WORD_SEL_W];
    assign cur_line = data_q[req_idx];
    assign cur_word = cur_line[{req_word, {WORD_SHIFT{1'b0}}} +: WORD_SIZE];

    assign lookup_hit = (state_q == READY) && cache_bus.valid &&
                        valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign cache_bus.hit     = lookup_hit;
    assign cache_bus.data_rd = cur_word;

    always_comb begin
        state_d            = state_q;
        valid_d            = valid_q;
        dirty_d            = dirty_q;
        line_we            = 1'b0;
        line_wdata         = cur_line;
        tag_we             = 1'b0;
        memory_bus.valid   = 1'b0;
        memory_bus.write   = 1'b0;
        memory_bus.addr    = '0;
        memory_bus.data_wr = cur_line;

        case (state_q)
            READY: begin
                if (cache_bus.valid) begin
                    if (lookup_hit) begin
                        if (cache_bus.write) begin
                            line_we = 1'b1;
                            line_wdata[{req_word, {WORD_SHIFT{1'b0}}} +: WORD_SIZE] =
                                merge_store(cur_word, cache_bus.data_wr,
                                            cache_bus.wr_size, cache_bus.addr[1:0]);
                            dirty_d[req_idx] = 1'b1;
                        end
                    end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                        state_d = EVICT;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            EVICT: begin
                memory_bus.valid = 1'b1;
                memory_bus.write = 1'b1;
                memory_bus.addr  = {tag_q[req_idx], req_idx, {OFFSET_W{1'b0}}};
                if (memory_bus.ready) begin
                    dirty_d[req_idx] = 1'b0;
                    state_d          = FILL;
                end
            end
            FILL: begin
                memory_bus.valid = 1'b1;
                memory_bus.addr  = {req_tag, req_idx, {OFFSET_W{1'b0}}};
                if (memory_bus.ready) begin
                    line_we          = 1'b1;
                    line_wdata       = memory_bus.data_rd;
                    tag_we           = 1'b1;
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = 1'b0;
                    state_d          = READY;
                end
            end
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= READY;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clk_i) begin
        if (line_we) begin
            data_q[req_idx] <= line_wdata;
        end
        if (tag_we) begin
            tag_q[req_idx] <= req_tag;
        end
    end

endmodule

// File: tb/tb_cache.sv
// Directed bench for the cache: hit vectors from a table, miss/evict/reset by hand.
module tb_cache;
    import cache_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    cache_interface  cbus();
    memory_interface mbus();

    cache dut (
        .clk_i      (clk),
        .reset_i    (rst_n),
        .cache_bus  (cbus),
        .memory_bus (mbus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         vld;
        logic         wr;
        access_size_t sz;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic         exp_hit;
        logic         chk_rd;
        logic [31:0]  exp_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic vld, input logic wr, input access_size_t sz,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic eh, input logic cr, input logic [31:0] er);
        vec_t v;
        v.vld = vld; v.wr = wr; v.sz = sz; v.addr = a; v.wdata = d;
        v.exp_hit = eh; v.chk_rd = cr; v.exp_rd = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [LINE_SIZE-1:0] act,
                       input logic [LINE_SIZE-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic req(input logic wr, input access_size_t sz,
                       input logic [31:0] a, input logic [31:0] d);
        cbus.valid   = 1'b1;
        cbus.write   = wr;
        cbus.wr_size = sz;
        cbus.addr    = a;
        cbus.data_wr = d;
    endtask

    // Waits for a memory request, checks it, holds it for lat cycles, then pulses ready.
    task automatic mem_xfer(input string name, input logic exp_write,
                            input logic [31:0] exp_addr, input logic chk_line,
                            input logic [LINE_SIZE-1:0] exp_line,
                            input logic [LINE_SIZE-1:0] rdata, input int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!mbus.valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, mbus.valid, 1'b1);
        if (!mbus.valid) return;
        chk({name, "_addr"}, mbus.addr, exp_addr);
        chk({name, "_write"}, mbus.write, exp_write);
        chk({name, "_hit_low"}, cbus.hit, 1'b0);
        if (chk_line) chk({name, "_line"}, mbus.data_wr, exp_line);
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            chk({name, "_hold_valid"}, mbus.valid, 1'b1);
            chk({name, "_hold_addr"}, mbus.addr, exp_addr);
        end
        mbus.ready   = 1'b1;
        mbus.data_rd = rdata;
        @(posedge clk);
        #1;
        mbus.ready   = 1'b0;
        mbus.data_rd = '0;
    endtask

    logic [LINE_SIZE-1:0] line_a, line_b, line_c, ev;

    initial begin
        int n;
        for (int i = 0; i < 8; i++) begin
            line_a[i*32 +: 32] = 32'h1111_1111 * i;
            line_b[i*32 +: 32] = 32'hB000_0000 + i;
            line_c[i*32 +: 32] = 32'hC000_0000 + i;
        end
        line_a[31:0]  = 32'hDEAD_BEEF;
        line_a[63:32] = 32'hCAFE_F00D;
        ev = line_a;
        ev[31:0]  = 32'hBEEF_AA44;
        ev[63:32] = 32'hCAFE_5566;
        ev[95:64] = 32'h9922_2222;

        vecs.push_back(mk(1, 0, WORD, 32'h104, 32'h0,         1, 1, 32'hCAFE_F00D));
        vecs.push_back(mk(1, 0, WORD, 32'h103, 32'h0,         1, 1, 32'hDEAD_BEEF));
        vecs.push_back(mk(1, 0, WORD, 32'h11C, 32'h0,         1, 1, 32'h7777_7777));
        vecs.push_back(mk(0, 0, WORD, 32'h100, 32'h0,         0, 0, 32'h0));
        vecs.push_back(mk(1, 1, WORD, 32'h100, 32'h1122_3344, 1, 0, 32'h0));
        vecs.push_back(mk(1, 0, WORD, 32'h100, 32'h0,         1, 1, 32'h1122_3344));
        vecs.push_back(mk(1, 1, BYTE, 32'h101, 32'hFFFF_FFAA, 1, 0, 32'h0));
        vecs.push_back(mk(1, 0, WORD, 32'h100, 32'h0,         1, 1, 32'h1122_AA44));
        vecs.push_back(mk(1, 1, HALF, 32'h102, 32'h1234_BEEF, 1, 0, 32'h0));
        vecs.push_back(mk(1, 0, WORD, 32'h100, 32'h0,         1, 1, 32'hBEEF_AA44));
        vecs.push_back(mk(1, 1, HALF, 32'h104, 32'h0000_5566, 1, 0, 32'h0));
        vecs.push_back(mk(1, 0, WORD, 32'h104, 32'h0,         1, 1, 32'hCAFE_5566));
        vecs.push_back(mk(1, 1, BYTE, 32'h10B, 32'h0000_0099, 1, 0, 32'h0));
        vecs.push_back(mk(1, 0, WORD, 32'h108, 32'h0,         1, 1, 32'h9922_2222));
        vecs.push_back(mk(1, 0, WORD, 32'h10C, 32'h0,         1, 1, 32'h3333_3333));

        mbus.ready   = 1'b0;
        mbus.data_rd = '0;
        req(1'b0, WORD, 32'h100, 32'h0);

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_hit", cbus.hit, 1'b0);
        chk("rst_mem_valid", mbus.valid, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // first load misses and fills
        @(negedge clk);
        chk("miss_hit", cbus.hit, 1'b0);
        mem_xfer("fill_a", 1'b0, 32'h100, 1'b0, '0, line_a, 2);
        @(negedge clk);
        chk("fill_a_hit", cbus.hit, 1'b1);
        chk("fill_a_rd", cbus.data_rd, 32'hDEAD_BEEF);
        chk("fill_a_valid_drop", mbus.valid, 1'b0);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            cbus.valid   = vecs[i].vld;
            cbus.write   = vecs[i].wr;
            cbus.wr_size = vecs[i].sz;
            cbus.addr    = vecs[i].addr;
            cbus.data_wr = vecs[i].wdata;
            @(negedge clk);
            chk($sformatf("vec%0d_hit", i), cbus.hit, vecs[i].exp_hit);
            chk($sformatf("vec%0d_mem_idle", i), mbus.valid, 1'b0);
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd", i), cbus.data_rd, vecs[i].exp_rd);
            @(posedge clk);
            #1;
        end

        // dirty conflict: evict merged line, then fill new tag
        req(1'b0, WORD, 32'h1100, 32'h0);
        @(negedge clk);
        chk("conf_miss_hit", cbus.hit, 1'b0);
        mem_xfer("evict", 1'b1, 32'h100, 1'b1, ev, '0, 2);
        mem_xfer("fill_b", 1'b0, 32'h1100, 1'b0, '0, line_b, 3);
        @(negedge clk);
        chk("fill_b_hit", cbus.hit, 1'b1);
        chk("fill_b_rd", cbus.data_rd, 32'hB000_0000);
        chk("fill_b_valid_drop", mbus.valid, 1'b0);
        @(posedge clk);
        #1;
        cbus.addr = 32'h1114;
        @(negedge clk);
        chk("fill_b_w5_hit", cbus.hit, 1'b1);
        chk("fill_b_w5_rd", cbus.data_rd, 32'hB000_0005);
        @(posedge clk);
        #1;

        // clean conflict: no eviction expected
        req(1'b0, WORD, 32'h104, 32'h0);
        @(negedge clk);
        chk("clean_miss_hit", cbus.hit, 1'b0);
        mem_xfer("refill_a", 1'b0, 32'h100, 1'b0, '0, line_a, 1);
        @(negedge clk);
        chk("refill_a_hit", cbus.hit, 1'b1);
        chk("refill_a_rd", cbus.data_rd, 32'hCAFE_F00D);
        @(posedge clk);
        #1;

        // stray ready in READY is ignored
        cbus.valid   = 1'b0;
        mbus.ready   = 1'b1;
        mbus.data_rd = {8{32'h0BAD_F00D}};
        @(posedge clk);
        #1;
        mbus.ready   = 1'b0;
        mbus.data_rd = '0;
        req(1'b0, WORD, 32'h104, 32'h0);
        @(negedge clk);
        chk("stray_hit", cbus.hit, 1'b1);
        chk("stray_rd", cbus.data_rd, 32'hCAFE_F00D);
        chk("stray_mem_idle", mbus.valid, 1'b0);
        @(posedge clk);
        #1;

        // reset in the middle of a fill
        req(1'b0, WORD, 32'h2100, 32'h0);
        n = 0;
        @(negedge clk);
        while (!mbus.valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rfill_started", mbus.valid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rfill_valid_drop", mbus.valid, 1'b0);
        chk("rfill_hit", cbus.hit, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rfill_after_hit", cbus.hit, 1'b0);
        mem_xfer("fill_c", 1'b0, 32'h2100, 1'b0, '0, line_c, 2);
        @(negedge clk);
        chk("fill_c_hit", cbus.hit, 1'b1);
        chk("fill_c_rd", cbus.data_rd, 32'hC000_0000);
        @(posedge clk);
        #1;
        cbus.valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
